// File: rtl/qlearn_pkg.sv
// Shared constants, FSM encoding and LFSR step for the Q-learning core.
package qlearn_pkg;

  localparam int unsigned Q_WIDTH       = 16;
  localparam int unsigned STATES_WIDTH  = 4;
  localparam int unsigned NUM_ACTIONS   = 4;
  localparam int unsigned ACTIONS_WIDTH = $clog2(NUM_ACTIONS);
  localparam int unsigned LFSR_WIDTH    = 16;

  localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 16'hB400;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } fsm_state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/qlearn_lfsr16.sv
// 16-bit Galois LFSR with explicit advance, synchronous load and optional
// replacement of an all-zero seed (an all-zero state would lock up).
module qlearn_lfsr16
  import qlearn_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = LFSR_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic                  load,
  input  logic                  zero_sub,
  input  logic [LFSR_WIDTH-1:0] load_value,
  output logic [LFSR_WIDTH-1:0] value
);

  logic load_zero;

  assign load_zero = zero_sub && (load_value == '0);

  // LFSR state: load has priority over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (load) begin
      value <= load_zero ? SEED : load_value;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/qlearn_action_select.sv
// Epsilon-greedy action selector: scans a state's Q-values, tracks the signed
// maximum (lowest index on ties) and returns either the greedy action or an
// LFSR-drawn exploratory action.
module qlearn_action_select #(
  parameter int unsigned NUM_ACTIONS   = qlearn_pkg::NUM_ACTIONS,
  parameter int unsigned STATES_WIDTH  = qlearn_pkg::STATES_WIDTH,
  parameter int unsigned Q_WIDTH       = qlearn_pkg::Q_WIDTH,
  parameter logic [15:0] LFSR_SEED     = qlearn_pkg::LFSR_SEED,
  localparam int unsigned ACTIONS_WIDTH = $clog2(NUM_ACTIONS),
  localparam int unsigned ADDR_WIDTH    = STATES_WIDTH + ACTIONS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [STATES_WIDTH-1:0]  i_state,
  input  logic [15:0]              i_epsilon,
  input  logic                     i_seed_load,
  input  logic [15:0]              i_seed,
  output logic                     o_rd_en,
  output logic [ADDR_WIDTH-1:0]    o_rd_addr,
  input  logic [Q_WIDTH-1:0]       i_rd_data,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic [ACTIONS_WIDTH-1:0] o_action,
  output logic                     o_explore,
  output logic [Q_WIDTH-1:0]       o_qmax,
  output logic [Q_WIDTH-1:0]       o_qsel
);

  import qlearn_pkg::*;

  localparam logic [ACTIONS_WIDTH-1:0] LAST_ACTION = ACTIONS_WIDTH'(NUM_ACTIONS - 1);

  fsm_state_e state, state_n;
  logic       accept, seed_ld, scan_last;

  logic [15:0]               lfsr_val;
  logic [ACTIONS_WIDTH-1:0]  ea_c;
  logic [ACTIONS_WIDTH-1:0]  cnt;
  logic [ACTIONS_WIDTH-1:0]  ea_q;
  logic [STATES_WIDTH-1:0]   st_q;
  logic                      explore_q;

  logic                      data_v;
  logic [ACTIONS_WIDTH-1:0]  data_idx;
  logic signed [Q_WIDTH-1:0] rd_q;
  logic signed [Q_WIDTH-1:0] max_q, max_n;
  logic signed [Q_WIDTH-1:0] qea_q, qea_n;
  logic [ACTIONS_WIDTH-1:0]  arg_q, arg_n;

  assign rd_q = $signed(i_rd_data);

  // Exploratory action: scale the low LFSR byte into 0..NUM_ACTIONS-1.
  assign ea_c = ACTIONS_WIDTH'((32'(lfsr_val[7:0]) * NUM_ACTIONS) >> 8);

  // Exploration random source; advances once per accepted request.
  qlearn_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (accept),
    .load       (seed_ld),
    .zero_sub   (1'b1),
    .load_value (i_seed),
    .value      (lfsr_val)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, acceptance and seed-load decode; seed load beats a request.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    seed_ld   = 1'b0;
    scan_last = (cnt == LAST_ACTION);
    case (state)
      IDLE: begin
        if (i_seed_load) begin
          seed_ld = 1'b1;
        end else if (i_req) begin
          accept  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN:    if (scan_last) state_n = LAST;
      LAST:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request capture and Q-memory address sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= '0;
      cnt       <= '0;
      ea_q      <= '0;
      explore_q <= 1'b0;
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
      o_busy    <= 1'b0;
    end else begin
      o_busy <= (state_n != IDLE);
      if (accept) begin
        st_q      <= i_state;
        cnt       <= '0;
        ea_q      <= ea_c;
        explore_q <= (lfsr_val < i_epsilon);
        o_rd_en   <= 1'b1;
        o_rd_addr <= {i_state, ACTIONS_WIDTH'(0)};
      end else if (state == SCAN) begin
        if (scan_last) begin
          o_rd_en <= 1'b0;
        end else begin
          cnt       <= cnt + ACTIONS_WIDTH'(1);
          o_rd_addr <= {st_q, cnt + ACTIONS_WIDTH'(1)};
        end
      end
    end
  end

  // Running max/argmax over returned words; first word seeds the max.
  always_comb begin
    max_n = max_q;
    arg_n = arg_q;
    qea_n = qea_q;
    if (data_v) begin
      if ((data_idx == '0) || (rd_q > max_q)) begin
        max_n = rd_q;
        arg_n = data_idx;
      end
      if (data_idx == ea_q) begin
        qea_n = rd_q;
      end
    end
  end

  // Read-data alignment and running compare registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_v   <= 1'b0;
      data_idx <= '0;
      max_q    <= '0;
      arg_q    <= '0;
      qea_q    <= '0;
    end else begin
      data_v   <= o_rd_en;
      data_idx <= o_rd_addr[ACTIONS_WIDTH-1:0];
      max_q    <= max_n;
      arg_q    <= arg_n;
      qea_q    <= qea_n;
    end
  end

  // Result registers, loaded at the end of LAST and held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_action  <= '0;
      o_explore <= 1'b0;
      o_qmax    <= '0;
      o_qsel    <= '0;
    end else begin
      o_valid <= (state == LAST);
      if (state == LAST) begin
        o_explore <= explore_q;
        o_action  <= explore_q ? ea_q : arg_n;
        o_qmax    <= max_n;
        o_qsel    <= explore_q ? qea_n : max_n;
      end
    end
  end

endmodule

// File: tb/tb_qlearn_action_select.sv
// Bench for qlearn_action_select: N=4 and N=3 instances against a
// transaction-level epsilon-greedy model, plus hand-computed expectations.
module tb_qlearn_action_select;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req4, sl4, rd_en4, busy4, valid4, expl4;
  logic [3:0]  st4;
  logic [15:0] eps4, seed4, rdata4, qmax4, qsel4;
  logic [5:0]  addr4;
  logic [1:0]  act4;

  logic        req3, sl3, rd_en3, busy3, valid3, expl3;
  logic [3:0]  st3;
  logic [15:0] eps3, seed3, rdata3, qmax3, qsel3;
  logic [5:0]  addr3;
  logic [1:0]  act3;

  qlearn_action_select #(.NUM_ACTIONS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_req(req4), .i_state(st4), .i_epsilon(eps4),
    .i_seed_load(sl4), .i_seed(seed4), .o_rd_en(rd_en4), .o_rd_addr(addr4),
    .i_rd_data(rdata4), .o_busy(busy4), .o_valid(valid4), .o_action(act4),
    .o_explore(expl4), .o_qmax(qmax4), .o_qsel(qsel4)
  );

  qlearn_action_select #(.NUM_ACTIONS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_req(req3), .i_state(st3), .i_epsilon(eps3),
    .i_seed_load(sl3), .i_seed(seed3), .o_rd_en(rd_en3), .o_rd_addr(addr3),
    .i_rd_data(rdata3), .o_busy(busy3), .o_valid(valid3), .o_action(act3),
    .o_explore(expl3), .o_qmax(qmax3), .o_qsel(qsel3)
  );

  typedef struct packed {
    logic        rd_en;
    logic [5:0]  addr;
    logic        busy;
    logic        valid;
    logic [1:0]  act;
    logic        expl;
    logic [15:0] qmax;
    logic [15:0] qsel;
  } obs_t;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  logic signed [15:0] qm [2][64];
  logic [15:0] lfsr_m [2];
  bit          active [2];
  int          t_acc  [2];
  int          st_m   [2];
  int          p_act  [2];
  int          h_act  [2];
  bit          p_expl [2];
  bit          h_expl [2];
  logic [15:0] p_qmax [2];
  logic [15:0] p_qsel [2];
  logic [15:0] h_qmax [2];
  logic [15:0] h_qsel [2];
  int          vcnt   [2];
  int          last_vcyc [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Q memory: data is returned the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en4) rdata4 <= qm[0][addr4];
    if (rd_en3) rdata3 <= qm[1][addr3];
  end

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic obs_t obs(input int d);
    obs_t o;
    if (d == 0) o = '{rd_en4, addr4, busy4, valid4, act4, expl4, qmax4, qsel4};
    else        o = '{rd_en3, addr3, busy3, valid3, act3, expl3, qmax3, qsel3};
    return o;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
  endtask

  // Epsilon-greedy decision from the rules, applied to the model memory.
  task automatic model_accept(input int d, input int s, input logic [15:0] e);
    logic [15:0] r;
    int n, best, ea, act;
    bit expl;
    n = n_of(d);
    r = lfsr_m[d];
    lfsr_m[d] = lfsr_next(r);
    best = 0;
    for (int k = 1; k < n; k++)
      if (qm[d][s*4+k] > qm[d][s*4+best]) best = k;
    expl = (r < e);
    ea   = (int'(r[7:0]) * n) / 256;
    act  = expl ? ea : best;
    p_act[d]  = act;
    p_expl[d] = expl;
    p_qmax[d] = qm[d][s*4+best];
    p_qsel[d] = qm[d][s*4+act];
    st_m[d]   = s;
    active[d] = 1'b1;
    t_acc[d]  = cyc + 1;
  endtask

  // Drive one cycle of request / seed-load and update the model.
  task automatic drive(input int d, input bit rq, input bit sl, input int s,
                       input logic [15:0] e, input logic [15:0] sd);
    int n;
    bit idle;
    n = n_of(d);
    idle = !active[d] || (cyc >= t_acc[d] + n + 2);
    if (d == 0) begin req4 = rq; sl4 = sl; st4 = 4'(s); eps4 = e; seed4 = sd; end
    else        begin req3 = rq; sl3 = sl; st3 = 4'(s); eps3 = e; seed3 = sd; end
    if (sl && idle) lfsr_m[d] = (sd == 16'h0) ? 16'hACE1 : sd;
    else if (rq && idle) model_accept(d, s, e);
    @(posedge clk); #1;
    if (d == 0) begin req4 = 1'b0; sl4 = 1'b0; end
    else        begin req3 = 1'b0; sl3 = 1'b0; end
  endtask

  task automatic do_req(input int d, input int s, input logic [15:0] e);
    drive(d, 1'b1, 1'b0, s, e, 16'h0);
  endtask

  task automatic load_seed(input int d, input logic [15:0] sd);
    drive(d, 1'b0, 1'b1, 0, 16'h0, sd);
  endtask

  task automatic wait_done(input int d);
    while (cyc < t_acc[d] + n_of(d) + 2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int k);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      active[d] = 1'b0; lfsr_m[d] = 16'hACE1;
      h_act[d] = 0; h_expl[d] = 1'b0; h_qmax[d] = '0; h_qsel[d] = '0;
    end
    tick(k);
    rst_n = 1'b1;
  endtask

  task automatic set_q(input int d, input int s, input int q0, input int q1, input int q2, input int q3);
    qm[d][s*4+0] = 16'(q0);
    qm[d][s*4+1] = 16'(q1);
    qm[d][s*4+2] = 16'(q2);
    qm[d][s*4+3] = 16'(q3);
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      obs_t o;
      int n, rel;
      o   = obs(d);
      n   = n_of(d);
      rel = active[d] ? (cyc - t_acc[d]) : -1;
      check("rd_en", d, 32'(o.rd_en), 32'(rel >= 0 && rel < n));
      if (rel >= 0 && rel < n) check("rd_addr", d, 32'(o.addr), 32'(st_m[d]*4 + rel));
      check("busy", d, 32'(o.busy), 32'(rel >= 0 && rel <= n + 1));
      check("valid", d, 32'(o.valid), 32'(rel == n + 1));
      if (rel == n + 1) begin
        h_act[d] = p_act[d]; h_expl[d] = p_expl[d];
        h_qmax[d] = p_qmax[d]; h_qsel[d] = p_qsel[d];
      end
      if (o.valid === 1'b1) begin
        vcnt[d]++;
        last_vcyc[d] = cyc;
      end
      check("action", d, 32'(o.act), 32'(h_act[d]));
      check("explore", d, 32'(o.expl), 32'(h_expl[d]));
      check("qmax", d, 32'(o.qmax), 32'(h_qmax[d]));
      check("qsel", d, 32'(o.qsel), 32'(h_qsel[d]));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v0;
    logic [15:0] sd;
    int s;
    req4 = 0; sl4 = 0; st4 = 0; eps4 = 0; seed4 = 0;
    req3 = 0; sl3 = 0; st3 = 0; eps3 = 0; seed3 = 0;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 64; a++) qm[d][a] = '0;
      lfsr_m[d] = 16'hACE1; active[d] = 1'b0; t_acc[d] = 0; st_m[d] = 0;
      h_act[d] = 0; h_expl[d] = 1'b0; h_qmax[d] = '0; h_qsel[d] = '0;
      p_act[d] = 0; p_expl[d] = 1'b0; p_qmax[d] = '0; p_qsel[d] = '0;
      vcnt[d] = 0; last_vcyc[d] = 0;
    end

    tick(3);
    rst_n = 1'b1;
    check("rst_busy", 0, 32'(busy4), 32'h0);
    check("rst_valid", 0, 32'(valid4), 32'h0);
    check("rst_rd_addr", 0, 32'(addr4), 32'h0);
    check("rst_qmax", 0, 32'(qmax4), 32'h0);

    // Seed read-back after reset: r = ACE1, ea = 0xE1*4>>8 = 3.
    set_q(0, 0, 1, 2, 3, 4);
    do_req(0, 0, 16'hFFFF);
    wait_done(0);
    check("seed_explore", 0, 32'(expl4), 32'h1);
    check("seed_action", 0, 32'(act4), 32'h3);
    check("seed_qsel", 0, 32'(qsel4), 32'h4);

    // Exploit with ties at state 3.
    set_q(0, 3, -5, 12, 12, 7);
    do_req(0, 3, 16'h0);
    wait_done(0);
    check("tie_latency", 0, 32'(last_vcyc[0] - t_acc[0]), 32'd5);
    check("tie_action", 0, 32'(act4), 32'h1);
    check("tie_qmax", 0, 32'(qmax4), 32'h000C);
    check("tie_qsel", 0, 32'(qsel4), 32'h000C);
    check("tie_explore", 0, 32'(expl4), 32'h0);

    // All-negative values, signed compare.
    set_q(0, 5, -100, -3, -3, -50);
    do_req(0, 5, 16'h0);
    wait_done(0);
    check("neg_action", 0, 32'(act4), 32'h1);
    check("neg_qmax", 0, 32'(qmax4), 32'hFFFD);

    // Explore with seed 0x0080: ea = 128*4>>8 = 2.
    set_q(0, 2, 1, 9, 4, 2);
    load_seed(0, 16'h0080);
    do_req(0, 2, 16'hFFFF);
    wait_done(0);
    check("exp_explore", 0, 32'(expl4), 32'h1);
    check("exp_action", 0, 32'(act4), 32'h2);
    check("exp_qsel", 0, 32'(qsel4), 32'h4);
    check("exp_qmax", 0, 32'(qmax4), 32'h9);

    // Zero seed substitutes ACE1: ea = 3.
    load_seed(0, 16'h0);
    do_req(0, 2, 16'hFFFF);
    wait_done(0);
    check("zseed_action", 0, 32'(act4), 32'h3);
    check("zseed_qsel", 0, 32'(qsel4), 32'h2);

    // Second request while busy is ignored.
    v0 = vcnt[0];
    set_q(0, 1, 7, 3, 9, 1);
    do_req(0, 1, 16'h0);
    tick(2);
    do_req(0, 6, 16'h0);
    wait_done(0);
    tick(2);
    check("busy_one_valid", 0, 32'(vcnt[0] - v0), 32'd1);
    check("busy_action", 0, 32'(act4), 32'h2);

    // Seed load and request together: seed wins, no acceptance.
    v0 = vcnt[0];
    set_q(0, 4, 10, 20, 30, 40);
    drive(0, 1'b1, 1'b1, 4, 16'hFFFF, 16'h1234);
    tick(6);
    check("conflict_no_valid", 0, 32'(vcnt[0] - v0), 32'd0);
    check("conflict_busy", 0, 32'(busy4), 32'h0);
    do_req(0, 4, 16'hFFFF);
    wait_done(0);
    check("conflict_action", 0, 32'(act4), 32'h0);
    check("conflict_qsel", 0, 32'(qsel4), 32'd10);

    // Reset mid-scan aborts; next request behaves as from power-up.
    v0 = vcnt[0];
    do_req(0, 3, 16'h0);
    tick(2);
    do_reset(1);
    tick(8);
    check("abort_no_valid", 0, 32'(vcnt[0] - v0), 32'd0);
    do_req(0, 0, 16'hFFFF);
    wait_done(0);
    check("abort_action", 0, 32'(act4), 32'h3);
    check("abort_explore", 0, 32'(expl4), 32'h1);

    // N=3 instance.
    set_q(1, 2, 3, -1, 8, 0);
    do_req(1, 2, 16'h0);
    wait_done(1);
    check("n3_latency", 1, 32'(last_vcyc[1] - t_acc[1]), 32'd4);
    check("n3_action", 1, 32'(act3), 32'h2);
    check("n3_qmax", 1, 32'(qmax3), 32'h8);

    for (int i = 0; i < 1000; i++) begin
      s  = $urandom_range(0, 15);
      for (int k = 0; k < 3; k++) qm[1][s*4+k] = 16'($urandom_range(0, 65535));
      sd = 16'($urandom_range(0, 65535));
      load_seed(1, sd);
      do_req(1, s, 16'hFFFF);
      wait_done(1);
      check("n3_ea_range", 1, 32'(act3 < 2'd3), 32'h1);
    end

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
